// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the core data port and the memory responder.
// The core drives the master side; the responder implements the slave side.
interface dmem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready, with a configurable
// number of wait states before the word-organised RAM is accessed.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int  IDX_W     = $clog2(DEPTH_WORDS);
  localparam int  STRB_W    = DATA_WIDTH / 8;
  localparam bit  ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("dmem_responder: DATA_WIDTH must be 32");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    ready_c, valid_c;

  logic                    write_p0;
  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic [DATA_WIDTH-1:0]   wdata_p0;
  logic [STRB_W-1:0]       wstrb_p0;

  logic [DATA_WIDTH-1:0]   rdata_p1;
  logic                    err_p1;

  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  logic                    accept, access;
  logic                    acc_write, acc_err;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [STRB_W-1:0]       acc_wstrb;
  logic [IDX_W-1:0]        acc_idx;

  function automatic logic addr_error(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= ADDR_LIMIT);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

  // With no wait states the access happens on the accept edge, straight from the bus.
  assign accept    = (state == IDLE) && bus.req_valid;
  assign access    = (ZERO_WAIT && accept) || (state == BUSY && cnt == 4'd0);
  assign acc_write = ZERO_WAIT ? bus.req_write : write_p0;
  assign acc_addr  = ZERO_WAIT ? bus.req_addr  : addr_p0;
  assign acc_wdata = ZERO_WAIT ? bus.req_wdata : wdata_p0;
  assign acc_wstrb = ZERO_WAIT ? bus.req_wstrb : wstrb_p0;
  assign acc_idx   = acc_addr[IDX_W+1:2];
  assign acc_err   = addr_error(acc_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    valid_c   = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) state_nxt = ZERO_WAIT ? RESP : BUSY;
      end
      BUSY: if (cnt == 4'd0) state_nxt = RESP;
      RESP: begin
        valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= 4'd0;
    else if (accept)                 cnt <= CNT_INIT;
    else if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // p0: request captured at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0 <= bus.req_write;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
      wstrb_p0 <= bus.req_wstrb;
    end
  end

  // p1: response held from access until the requester takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (access) begin
      err_p1   <= acc_err;
      rdata_p1 <= (acc_err || acc_write) ? '0 : mem[acc_idx];
    end else if (state == RESP && bus.rsp_ready) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && access && acc_write && !acc_err)
      mem[acc_idx] <= merge_bytes(mem[acc_idx], acc_wdata, acc_wstrb);
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = valid_c;
  assign bus.rsp_rdata = rdata_p1;
  assign bus.rsp_err   = err_p1;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait-state instance for most scenarios and a
// zero-wait instance for the single-cycle and back-to-back cases.
module tb_dmem_responder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b2 ();
  dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_req2(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic er,
                         output int lat);
    int guard;
    guard = 0;
    while (b2.req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    b2.req_valid = 1'b1; b2.req_write = w; b2.req_addr = a; b2.req_wdata = d; b2.req_wstrb = s;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    lat = 0;
    while (b2.rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    rd = b2.rsp_rdata;
    er = b2.rsp_err;
    b2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b2.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat;
    @(posedge clk); #1;
    b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_addr = 32'h0;
    b2.req_wdata = 32'h12345678; b2.req_wstrb = 4'hF;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (b2.req_ready !== 1'b1 || b2.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL reset_ctrl cyc%0d: ready=%b valid=%b, need 1/0", i, b2.req_ready, b2.rsp_valid);
      end
      checks++;
      if (b2.rsp_rdata !== 32'h0 || b2.rsp_err !== 1'b0) begin
        errors++; $display("FAIL reset_data cyc%0d: rdata=%h err=%b, need 0/0", i, b2.rsp_rdata, b2.rsp_err);
      end
    end
    b2.req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req2(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      errors++; $display("FAIL reset_no_access: rdata=%h err=%b, need a5a5a5a5/0", rd, er);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    do_req2(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    checks++;
    if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL sw_full: lat=%0d rdata=%h err=%b, need 2/0/0", lat, rd, er);
    end
    do_req2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL lw_full: lat=%0d rdata=%h err=%b, need 2/deadbeef/0", lat, rd, er);
    end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] rd; logic er; int lat;
    do_req2(1'b1, 32'h10, 32'h00000055, 4'b0001, rd, er, lat);
    do_req2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBE55) begin
      errors++; $display("FAIL strobe_b0: rdata=%h, need deadbe55", rd);
    end
    do_req2(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL strobe_none_rsp: lat=%0d rdata=%h err=%b, need 2/0/0", lat, rd, er);
    end
    do_req2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBE55) begin
      errors++; $display("FAIL strobe_none_data: rdata=%h, need deadbe55", rd);
    end
    do_req2(1'b1, 32'h10, 32'h12340000, 4'b1100, rd, er, lat);
    do_req2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h1234BE55) begin
      errors++; $display("FAIL strobe_hi: rdata=%h, need 1234be55", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_req2(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_misaligned_ld: lat=%0d rdata=%h err=%b, need 2/0/1", lat, rd, er);
    end
    do_req2(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_range_st: rdata=%h err=%b, need 0/1", rd, er);
    end
    do_req2(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      errors++; $display("FAIL err_range_word0: rdata=%h err=%b, need a5a5a5a5/0", rd, er);
    end
    do_req2(1'b1, 32'h11, 32'h00000000, 4'hF, rd, er, lat);
    do_req2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h1234BE55) begin
      errors++; $display("FAIL err_misaligned_st: rdata=%h, need 1234be55", rd);
    end
    do_req2(1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, rd, er, lat);
    do_req2(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0BADF00D || er !== 1'b0) begin
      errors++; $display("FAIL last_word: rdata=%h err=%b, need 0badf00d/0", rd, er);
    end
    do_req2(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++; $display("FAIL err_high_addr: rdata=%h err=%b, need 0/1", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    b2.req_valid = 1'b1; b2.req_write = 1'b0; b2.req_addr = 32'h10;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    lat = 0;
    while (b2.rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    // A competing store is offered while the response is stalled.
    b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_wdata = 32'h0; b2.req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (b2.rsp_valid !== 1'b1 || b2.req_ready !== 1'b0 ||
          b2.rsp_rdata !== 32'h1234BE55 || b2.rsp_err !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc%0d: valid=%b ready=%b rdata=%h err=%b, need 1/0/1234be55/0",
                           i, b2.rsp_valid, b2.req_ready, b2.rsp_rdata, b2.rsp_err);
      end
    end
    b2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b2.rsp_ready = 1'b0;
    b2.req_valid = 1'b0;
    checks++;
    if (b2.rsp_valid !== 1'b0 || b2.req_ready !== 1'b1 || b2.rsp_rdata !== 32'h0 || b2.rsp_err !== 1'b0) begin
      errors++; $display("FAIL bp_release: valid=%b ready=%b rdata=%h err=%b, need 0/1/0/0",
                         b2.rsp_valid, b2.req_ready, b2.rsp_rdata, b2.rsp_err);
    end
    do_req2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h1234BE55) begin
      errors++; $display("FAIL bp_no_sneak: rdata=%h, need 1234be55", rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int lat;
    do_req2(1'b1, 32'h20, 32'h11112222, 4'hF, rd, er, lat);
    b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_addr = 32'h20;
    b2.req_wdata = 32'h99999999; b2.req_wstrb = 4'hF;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b2.req_ready !== 1'b1 || b2.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL abort_async: ready=%b valid=%b, need 1/0", b2.req_ready, b2.rsp_valid);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_req2(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11112222) begin
      errors++; $display("FAIL abort_no_store: rdata=%h, need 11112222", rd);
    end
  endtask

  task automatic test_zero_wait();
    b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_addr = 32'h8;
    b0.req_wdata = 32'hCAFEF00D; b0.req_wstrb = 4'hF;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    checks++;
    if (b0.rsp_valid !== 1'b1 || b0.req_ready !== 1'b0 || b0.rsp_rdata !== 32'h0 || b0.rsp_err !== 1'b0) begin
      errors++; $display("FAIL zw_store: valid=%b ready=%b rdata=%h err=%b, need 1/0/0/0",
                         b0.rsp_valid, b0.req_ready, b0.rsp_rdata, b0.rsp_err);
    end
    b0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b0.rsp_ready = 1'b0;
    b0.req_valid = 1'b1; b0.req_write = 1'b0;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    checks++;
    if (b0.rsp_valid !== 1'b1 || b0.rsp_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL zw_load: valid=%b rdata=%h, need 1/cafef00d", b0.rsp_valid, b0.rsp_rdata);
    end
    b0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b0.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    b0.req_valid = 1'b1; b0.req_write = 1'b0; b0.req_addr = 32'h8;
    b0.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_v = (i % 2 == 0);
      checks++;
      if (b0.rsp_valid !== exp_v || (exp_v && b0.rsp_rdata !== 32'hCAFEF00D)) begin
        errors++; $display("FAIL b2b cyc%0d: valid=%b rdata=%h, need %b/cafef00d", i, b0.rsp_valid, b0.rsp_rdata, exp_v);
      end
    end
    b0.req_valid = 1'b0;
    b0.rsp_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd; logic er; int lat;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
    b2.req_wstrb = '0; b2.rsp_ready = 1'b0;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    b0.req_wstrb = '0; b0.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_req2(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    test_reset();
    test_store_load();
    test_byte_strobe();
    test_errors();
    test_backpressure();
    test_abort();
    test_zero_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, need completion");
    $fatal(1, "timeout");
  end
endmodule
